// File: rtl/text_term_pkg.sv
// Shared types, ASCII codes and helpers for the terminal write controller.
package text_term_pkg;

    // IDLE: wait for char | EXEC: decode | CLR_LINE: blank one row | CLR_ALL: blank screen
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_CLR_LINE = 2'd2,
        ST_CLR_ALL  = 2'd3
    } state_e;

    localparam logic [6:0] ASCII_BS       = 7'h08;
    localparam logic [6:0] ASCII_LF       = 7'h0A;
    localparam logic [6:0] ASCII_FF       = 7'h0C;
    localparam logic [6:0] ASCII_CR       = 7'h0D;
    localparam logic [6:0] ASCII_SPACE    = 7'h20;
    localparam logic [6:0] ASCII_PRINT_LO = 7'h20;
    localparam logic [6:0] ASCII_PRINT_HI = 7'h7E;

    localparam int BUNDLE_W        = 16;
    localparam int BUNDLE_BG_LSB   = 12;
    localparam int BUNDLE_FG_LSB   = 8;
    localparam int BUNDLE_PAD_BIT  = 7;
    localparam int BUNDLE_CHAR_LSB = 0;

    function automatic logic [BUNDLE_W-1:0] make_bundle(
        input logic [3:0] bg,
        input logic [3:0] fg,
        input logic [6:0] ch
    );
        logic [BUNDLE_W-1:0] b;
        b = '0;
        b[BUNDLE_BG_LSB +: 4]   = bg;
        b[BUNDLE_FG_LSB +: 4]   = fg;
        b[BUNDLE_PAD_BIT]       = 1'b0;
        b[BUNDLE_CHAR_LSB +: 7] = ch;
        return b;
    endfunction

    // Operands are already below m, so one conditional subtract is enough.
    function automatic logic [31:0] add_mod(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] m
    );
        logic [31:0] s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

endpackage

// File: rtl/text_term_ctrl_wrap_counter.sv
// Up-counter that wraps exactly at MAX-1, used to walk clear-sequence addresses.
module wrap_counter
    import text_term_pkg::*;
#(
    parameter int MAX = 10
) (
    input  logic                   clk_pix,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   clr,
    output logic [$clog2(MAX)-1:0] cnt,
    output logic                   at_max
);

    localparam int W = $clog2(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = (cnt_q == W'(MAX - 1));
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal-style write controller: cursor, control-code decode, ring-buffer
// scrolling via row_offset, and line/screen clear sequences.
module text_term_ctrl
    import text_term_pkg::*;
#(
    parameter int GRID_ROW     = 5,
    parameter int GRID_COL     = 10,
    parameter int ASCII_WIDTH  = 7,
    parameter int BUNDLE_WIDTH = 16
) (
    input  logic                        clk_pix,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ASCII_WIDTH-1:0]      in_char,
    input  logic [3:0]                  fg_idx,
    input  logic [3:0]                  bg_idx,
    output logic                        wr_en,
    output logic [$clog2(GRID_COL)-1:0] wr_col,
    output logic [$clog2(GRID_ROW)-1:0] wr_row,
    output logic [BUNDLE_WIDTH-1:0]     wr_data,
    output logic [$clog2(GRID_ROW)-1:0] row_offset,
    output logic [$clog2(GRID_COL)-1:0] cur_col,
    output logic [$clog2(GRID_ROW)-1:0] cur_row,
    output logic                        busy
);

    localparam int COL_W = $clog2(GRID_COL);
    localparam int ROW_W = $clog2(GRID_ROW);

    state_e                  state_q,      state_d;
    logic [COL_W-1:0]        cur_col_q,    cur_col_d;
    logic [ROW_W-1:0]        cur_row_q,    cur_row_d;
    logic [ROW_W-1:0]        row_offset_q, row_offset_d;
    logic [ROW_W-1:0]        clr_row_q,    clr_row_d;
    logic [ASCII_WIDTH-1:0]  char_q,       char_d;
    logic [3:0]              fg_q,         fg_d;
    logic [3:0]              bg_q,         bg_d;
    logic                    wr_en_q,      wr_en_d;
    logic [COL_W-1:0]        wr_col_q,     wr_col_d;
    logic [ROW_W-1:0]        wr_row_q,     wr_row_d;
    logic [BUNDLE_WIDTH-1:0] wr_data_q,    wr_data_d;

    logic [COL_W-1:0]        seq_col;
    logic [ROW_W-1:0]        seq_row;
    logic                    seq_col_max;
    logic                    seq_row_max;
    logic                    seq_col_inc;
    logic                    seq_row_inc;
    logic                    seq_clr;

    logic [ROW_W-1:0]        phys_row;
    logic [ROW_W-1:0]        offset_next;
    logic [BUNDLE_WIDTH-1:0] space_bundle;
    logic                    printable;
    logic                    newline;

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign busy       = (state_q == ST_CLR_LINE) || (state_q == ST_CLR_ALL);
    assign wr_en      = wr_en_q;
    assign wr_col     = wr_col_q;
    assign wr_row     = wr_row_q;
    assign wr_data    = wr_data_q;
    assign row_offset = row_offset_q;
    assign cur_col    = cur_col_q;
    assign cur_row    = cur_row_q;

    // Logical row 0 lives at physical row row_offset; the buffer is a ring.
    assign phys_row     = ROW_W'(add_mod(32'(cur_row_q), 32'(row_offset_q), 32'(GRID_ROW)));
    assign offset_next  = ROW_W'(add_mod(32'(row_offset_q), 32'd1, 32'(GRID_ROW)));
    assign space_bundle = BUNDLE_WIDTH'(make_bundle(bg_q, fg_q, ASCII_SPACE));
    assign printable    = (char_q >= ASCII_PRINT_LO) && (char_q <= ASCII_PRINT_HI);

    assign seq_col_inc = busy;
    assign seq_row_inc = (state_q == ST_CLR_ALL) && seq_col_max;
    assign seq_clr     = (state_q == ST_EXEC);

    wrap_counter #(.MAX(GRID_COL)) u_col_cnt (
        .clk_pix (clk_pix),
        .rst     (rst),
        .inc     (seq_col_inc),
        .clr     (seq_clr),
        .cnt     (seq_col),
        .at_max  (seq_col_max)
    );

    wrap_counter #(.MAX(GRID_ROW)) u_row_cnt (
        .clk_pix (clk_pix),
        .rst     (rst),
        .inc     (seq_row_inc),
        .clr     (seq_clr),
        .cnt     (seq_row),
        .at_max  (seq_row_max)
    );

    always_comb begin
        state_d      = state_q;
        cur_col_d    = cur_col_q;
        cur_row_d    = cur_row_q;
        row_offset_d = row_offset_q;
        clr_row_d    = clr_row_q;
        char_d       = char_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        wr_en_d      = 1'b0;
        wr_col_d     = wr_col_q;
        wr_row_d     = wr_row_q;
        wr_data_d    = wr_data_q;
        newline      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    char_d  = in_char;
                    fg_d    = fg_idx;
                    bg_d    = bg_idx;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                if (printable) begin
                    wr_en_d   = 1'b1;
                    wr_col_d  = cur_col_q;
                    wr_row_d  = phys_row;
                    wr_data_d = BUNDLE_WIDTH'(make_bundle(bg_q, fg_q, char_q));
                    if (cur_col_q < COL_W'(GRID_COL - 1)) begin
                        cur_col_d = cur_col_q + 1'b1;
                    end else begin
                        cur_col_d = '0;
                        newline   = 1'b1;
                    end
                end else if (char_q == ASCII_CR) begin
                    cur_col_d = '0;
                end else if (char_q == ASCII_LF) begin
                    newline = 1'b1;
                end else if (char_q == ASCII_BS) begin
                    if (cur_col_q != '0) begin
                        cur_col_d = cur_col_q - 1'b1;
                        wr_en_d   = 1'b1;
                        wr_col_d  = cur_col_q - 1'b1;
                        wr_row_d  = phys_row;
                        wr_data_d = space_bundle;
                    end
                end else if (char_q == ASCII_FF) begin
                    cur_col_d    = '0;
                    cur_row_d    = '0;
                    row_offset_d = '0;
                    state_d      = ST_CLR_ALL;
                end

                // Scrolling recycles the old top row as the new bottom row.
                if (newline) begin
                    if (cur_row_q < ROW_W'(GRID_ROW - 1)) begin
                        cur_row_d = cur_row_q + 1'b1;
                    end else begin
                        clr_row_d    = row_offset_q;
                        row_offset_d = offset_next;
                        state_d      = ST_CLR_LINE;
                    end
                end
            end

            ST_CLR_LINE: begin
                wr_en_d   = 1'b1;
                wr_col_d  = seq_col;
                wr_row_d  = clr_row_q;
                wr_data_d = space_bundle;
                if (seq_col_max) begin
                    state_d = ST_IDLE;
                end
            end

            ST_CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_col_d  = seq_col;
                wr_row_d  = seq_row;
                wr_data_d = space_bundle;
                if (seq_col_max && seq_row_max) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q      <= ST_CLR_ALL;
            cur_col_q    <= '0;
            cur_row_q    <= '0;
            row_offset_q <= '0;
            clr_row_q    <= '0;
            char_q       <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            wr_en_q      <= 1'b0;
            wr_col_q     <= '0;
            wr_row_q     <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_col_q    <= cur_col_d;
            cur_row_q    <= cur_row_d;
            row_offset_q <= row_offset_d;
            clr_row_q    <= clr_row_d;
            char_q       <= char_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            wr_en_q      <= wr_en_d;
            wr_col_q     <= wr_col_d;
            wr_row_q     <= wr_row_d;
            wr_data_q    <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Scoreboard bench for text_term_ctrl: a reference terminal model queues the
// expected buffer writes and a monitor matches them against wr_* in order.
module tb_text_term_ctrl;

    localparam int GR = 5;
    localparam int GC = 10;

    logic       clk_pix;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_char;
    logic [3:0] fg_idx;
    logic [3:0] bg_idx;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [2:0] wr_row;
    logic [15:0] wr_data;
    logic [2:0] row_offset;
    logic [3:0] cur_col;
    logic [2:0] cur_row;
    logic       busy;

    text_term_ctrl dut (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .fg_idx     (fg_idx),
        .bg_idx     (bg_idx),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .row_offset (row_offset),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .busy       (busy)
    );

    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    logic [31:0] exp_q[$];

    int m_col = 0;
    int m_row = 0;
    int m_off = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int phys(input int r);
        return (r + m_off) % GR;
    endfunction

    task automatic push_wr(input int r, input int c, input logic [15:0] d);
        logic [2:0] r3;
        logic [3:0] c4;
        r3 = 3'(r);
        c4 = 4'(c);
        exp_q.push_back({9'b0, r3, c4, d});
    endtask

    task automatic push_clear_all(input logic [3:0] f, input logic [3:0] b);
        for (int r = 0; r < GR; r++)
            for (int c = 0; c < GC; c++)
                push_wr(r, c, {b, f, 1'b0, 7'h20});
    endtask

    task automatic model_nl(input logic [3:0] f, input logic [3:0] b);
        int p;
        if (m_row < GR - 1) begin
            m_row++;
        end else begin
            p = m_off;
            m_off = (m_off + 1) % GR;
            for (int c = 0; c < GC; c++) push_wr(p, c, {b, f, 1'b0, 7'h20});
        end
    endtask

    task automatic model_char(input logic [6:0] c, input logic [3:0] f, input logic [3:0] b);
        if (c >= 7'h20 && c <= 7'h7E) begin
            push_wr(phys(m_row), m_col, {b, f, 1'b0, c});
            if (m_col < GC - 1) m_col++;
            else begin
                m_col = 0;
                model_nl(f, b);
            end
        end else if (c == 7'h0D) begin
            m_col = 0;
        end else if (c == 7'h0A) begin
            model_nl(f, b);
        end else if (c == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(phys(m_row), m_col, {b, f, 1'b0, 7'h20});
            end
        end else if (c == 7'h0C) begin
            m_col = 0;
            m_row = 0;
            m_off = 0;
            push_clear_all(f, b);
        end
    endtask

    // Returns #1 after the transfer edge.
    task automatic send(input logic [6:0] c, input logic [3:0] f, input logic [3:0] b);
        int n;
        n = 0;
        @(negedge clk_pix);
        while (!in_ready && n < 200) begin
            @(negedge clk_pix);
            n++;
        end
        if (!in_ready) begin
            check_val("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_char  = c;
        fg_idx   = f;
        bg_idx   = b;
        model_char(c, f, b);
        @(posedge clk_pix);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_pix);
        #1;
        while (!(in_ready && !busy && exp_q.size() == 0) && n < 500) begin
            @(negedge clk_pix);
            #1;
            n++;
        end
        check_val({tag, "_idle"}, 32'(in_ready && !busy && exp_q.size() == 0), 32'd1);
        check_val({tag, "_col"}, 32'(cur_col), 32'(m_col));
        check_val({tag, "_row"}, 32'(cur_row), 32'(m_row));
        check_val({tag, "_off"}, 32'(row_offset), 32'(m_off));
    endtask

    always @(negedge clk_pix) begin
        if (!rst && wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check_val("spurious_wr", 32'(wr_en), 32'd0);
            end else begin
                check_val("wr_row_col_data", {9'b0, wr_row, wr_col, wr_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int busy_cnt;
        int n;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = '0;
        fg_idx   = '0;
        bg_idx   = '0;
        push_clear_all(4'd0, 4'd0);

        repeat (3) @(posedge clk_pix);
        @(negedge clk_pix);
        check_val("ready_in_rst", 32'(in_ready), 32'd0);
        check_val("wr_en_in_rst", 32'(wr_en), 32'd0);
        rst = 1'b0;
        @(negedge clk_pix);
        #1;
        check_val("busy_after_rst", 32'(busy), 32'd1);
        wait_idle("rst_clear");
        check_val("rst_clear_count", 32'(wr_seen), 32'd50);

        // first character and its two-cycle write latency
        send(7'h41, 4'd3, 4'd1);
        @(negedge clk_pix);
        #1;
        check_val("a_wr_en_n1", 32'(wr_en), 32'd0);
        @(negedge clk_pix);
        #1;
        check_val("a_wr_en_n2", 32'(wr_en), 32'd1);
        check_val("a_col_n2", 32'(cur_col), 32'd1);
        wait_idle("a");

        send(7'h0D, 4'd3, 4'd1);
        wait_idle("cr");
        for (int i = 0; i < GC; i++) send(7'h42, 4'd7, 4'd2);
        wait_idle("b_wrap");

        base = wr_seen;
        send(7'h01, 4'd7, 4'd2);
        send(7'h7F, 4'd7, 4'd2);
        wait_idle("ignored");
        check_val("ignored_no_wr", 32'(wr_seen - base), 32'd0);

        for (int i = 0; i < 3; i++) send(7'h0A, 4'd7, 4'd2);
        send(7'h78, 4'd4, 4'd5);
        send(7'h79, 4'd4, 4'd5);
        send(7'h7A, 4'd4, 4'd5);
        wait_idle("row4_col3");
        send(7'h08, 4'd9, 4'd6);
        wait_idle("bs_col3");

        send(7'h0D, 4'd9, 4'd6);
        base = wr_seen;
        send(7'h08, 4'd9, 4'd6);
        wait_idle("bs_col0");
        check_val("bs_col0_no_wr", 32'(wr_seen - base), 32'd0);

        // scroll on LF at bottom row
        base = wr_seen;
        busy_cnt = 0;
        send(7'h0A, 4'd1, 4'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_pix);
            #1;
            if (busy) busy_cnt++;
        end
        check_val("scroll_busy_cycles", 32'(busy_cnt), 32'd10);
        check_val("scroll_wr_count", 32'(wr_seen - base), 32'd10);
        wait_idle("scroll_lf");

        // printable at the last column of the last row scrolls too
        for (int i = 0; i < GC; i++) send(7'(8'h30 + i), 4'd2, 4'd3);
        wait_idle("scroll_print");
        send(7'h0A, 4'd2, 4'd3);
        wait_idle("scroll_off3");

        base = wr_seen;
        send(7'h0C, 4'd6, 4'd2);
        wait_idle("ff_full");
        check_val("ff_full_count", 32'(wr_seen - base), 32'd50);

        // reset in the middle of a screen clear
        send(7'h41, 4'd1, 4'd1);
        send(7'h0A, 4'd1, 4'd1);
        wait_idle("pre_ff2");
        base = wr_seen;
        send(7'h0C, 4'd5, 4'd9);
        n = 0;
        while ((wr_seen - base) < 20 && n < 200) begin
            @(negedge clk_pix);
            #1;
            n++;
        end
        check_val("ff_word20_reached", 32'(wr_seen - base), 32'd20);
        rst = 1'b1;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        m_off = 0;
        push_clear_all(4'd0, 4'd0);
        @(negedge clk_pix);
        check_val("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        base = wr_seen;
        wait_idle("mid_rst_clear");
        check_val("mid_rst_count", 32'(wr_seen - base), 32'd50);

        send(7'h5A, 4'd15, 4'd14);
        wait_idle("post_rst_char");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
